jelly_axi4s_fifo_acceptable: RTL and testbench
==============================================

// Module: jelly_axi4s_fifo_acceptable
// PURPOSE
//  Synchronous AXI4-Stream FIFO placed directly downstream of the AXI4 DMA read stage.
//  Buffers {tdata,tlast} beats and exports its free-entry count as acceptable_counter.
//  The DMA reader's limiter uses that count to issue only bursts that are guaranteed to fit,
//  so the AXI4 R channel is never back-pressured by a slow stream consumer.
// PARAMETERS
//  DATA_WIDTH     32              tdata width
//  PTR_WIDTH      10              log2 of RAM depth; DEPTH = 2**PTR_WIDTH
//  COUNTER_WIDTH  PTR_WIDTH+1     width of acceptable_counter / data_count (must hold DEPTH)
//  RAM_TYPE       "block"         synthesis hint for the storage array
// PORTS
//  aresetn               in   1              synchronous reset, active low
//  aclk                  in   1              clock
//  s_axi4s_tdata         in   DATA_WIDTH     input beat data (from DMA reader)
//  s_axi4s_tlast         in   1              input beat last
//  s_axi4s_tvalid        in   1              input valid
//  s_axi4s_tready        out  1              input ready
//  m_axi4s_tdata         out  DATA_WIDTH     output beat data
//  m_axi4s_tlast         out  1              output beat last
//  m_axi4s_tvalid        out  1              output valid
//  m_axi4s_tready        in   1              output ready
//  acceptable_counter    out  COUNTER_WIDTH  free RAM entries (to DMA reader limiter)
//  data_count            out  COUNTER_WIDTH  occupied RAM entries (excludes output register)
// BEHAVIOUR
//  - Reset (aresetn=0 at posedge): wr_ptr=rd_ptr=0, out-reg empty; outputs: s_tready=0,
//    m_tvalid=0, m_tdata/m_tlast=0, acceptable_counter=DEPTH, data_count=0. Contents discarded;
//    reset mid-transfer drops all buffered beats, no partial packet emitted afterwards.
//  - Pointers are PTR_WIDTH+1 bits (wrap bit). count=wr_ptr-rd_ptr (mod 2**(PTR_WIDTH+1));
//    full = count==DEPTH, empty = count==0. Address = ptr[PTR_WIDTH-1:0], natural wrap.
//  - Write: s_tvalid&s_tready writes RAM[wr_ptr], wr_ptr+1. s_tready is a register:
//    1 in the cycle after reset release, then !full_next (no write accepted when full,
//    even if a read happens the same cycle; no fall-through).
//  - Read: synchronous RAM read into one output register. Read issued when !empty and
//    (!m_tvalid || m_tready); the register loads at that edge, rd_ptr+1, m_tvalid=1.
//    If m_tvalid&m_tready and no read issued, m_tvalid->0. m_tdata/m_tlast held stable
//    while m_tvalid&!m_tready (AXI4-Stream rule).
//  - Latency: beat accepted in cycle N into empty FIFO -> m_tvalid=1 in cycle N+2.
//    Full throughput: 1 beat/cycle sustained in and out simultaneously.
//  - Simultaneous write+read: count unchanged; pointers both advance.
//  - acceptable_counter = DEPTH - count, data_count = count, both registered (reflect
//    pointer state after the previous edge); conservative: the out-register beat is not
//    counted as free space. Never exceeds DEPTH, never underflows.
//  - tlast passes through unmodified; FIFO is packet-agnostic.
// TESTING  (PTR_WIDTH=4, DEPTH=16, DATA_WIDTH=32)
//  1 Reset: hold aresetn=0 3 cycles -> s_tready=0, m_tvalid=0, acceptable_counter=16,
//    data_count=0; first cycle after release s_tready=1.
//  2 Latency: write 0xA5A5_0001 tlast=1 at cycle N, m_tready=1 -> m_tvalid=1 at N+2 with
//    that data/tlast, deasserts N+3; acceptable_counter 16->15->16.
//  3 Fill: m_tready=0, stream 0..19 -> 16 RAM writes accepted plus 1 into out-reg
//    (17 beats total), s_tready=0 thereafter, acceptable_counter=0, data_count=16.
//  4 Drain after fill: m_tready=1 -> beats 0..16 emitted in order, one per cycle, no gaps;
//    s_tready returns 1 one cycle after first read frees space.
//  5 Streaming/wrap: 1000 beats, random tvalid/tready (50%) -> output sequence equals input
//    incl. tlast every 7th beat; pointers wrap >60 times; count always = writes-reads.
//  6 Reset mid-op: 10 beats buffered, m_tvalid=1 stalled, assert aresetn=0 one cycle ->
//    m_tvalid=0, acceptable_counter=16; old data never reappears on m_axi4s.

Source files
------------

// File: rtl/jelly_axi4s_fifo_acceptable_if.sv
`default_nettype none
// ============================================================================
// Module : jelly_axi4s_fifo_acceptable_if
// Desc   : AXI4-Stream beat channel (tdata/tlast/tvalid/tready) with master/slave views
// Rev    : 1.0  initial release
// ============================================================================
interface jelly_axi4s_fifo_acceptable_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tlast;
  logic                  tvalid;
  logic                  tready;

  modport master (output tdata, output tlast, output tvalid, input  tready);
  modport slave  (input  tdata, input  tlast, input  tvalid, output tready);
endinterface
`default_nettype wire

// File: rtl/jelly_axi4s_fifo_acceptable.sv
`default_nettype none
// ============================================================================
// Module : jelly_axi4s_fifo_acceptable
// Desc   : AXI4-Stream FIFO exporting its free-entry count for DMA burst limiting
// Rev    : 1.0  initial release
// ============================================================================
module jelly_axi4s_fifo_acceptable #(
  parameter int    DATA_WIDTH    = 32,
  parameter int    PTR_WIDTH     = 10,
  parameter int    COUNTER_WIDTH = PTR_WIDTH + 1,
  parameter string RAM_TYPE      = "block"
) (
  input  logic                             aresetn,
  input  logic                             aclk,
  jelly_axi4s_fifo_acceptable_if.slave     s_axi4s,
  jelly_axi4s_fifo_acceptable_if.master    m_axi4s,
  output logic [COUNTER_WIDTH-1:0]         acceptable_counter,
  output logic [COUNTER_WIDTH-1:0]         data_count
);

  localparam int               c_DEPTH = 2 ** PTR_WIDTH;
  localparam logic [PTR_WIDTH:0] c_FULL = {1'b1, {PTR_WIDTH{1'b0}}};

  logic [PTR_WIDTH:0]    r_wr_ptr;
  logic [PTR_WIDTH:0]    r_rd_ptr;
  logic                  r_s_tready;
  logic                  r_m_tvalid;
  logic [DATA_WIDTH-1:0] r_m_tdata;
  logic                  r_m_tlast;

  logic                  w_wr_en;
  logic                  w_rd_en;
  logic                  w_empty;
  logic [PTR_WIDTH:0]    w_count;
  logic [PTR_WIDTH:0]    w_wr_ptr_next;
  logic [PTR_WIDTH:0]    w_rd_ptr_next;
  logic [PTR_WIDTH:0]    w_count_next;
  logic [PTR_WIDTH-1:0]  w_wr_addr;
  logic [PTR_WIDTH-1:0]  w_rd_addr;
  logic [DATA_WIDTH:0]   w_rd_data;

  assign w_wr_en       = s_axi4s.tvalid & r_s_tready;
  assign w_count       = r_wr_ptr - r_rd_ptr;
  assign w_empty       = (w_count == '0);
  // The output register is refilled whenever it is empty or being drained this cycle
  assign w_rd_en       = !w_empty & (!r_m_tvalid | m_axi4s.tready);
  assign w_wr_ptr_next = r_wr_ptr + (PTR_WIDTH+1)'(w_wr_en);
  assign w_rd_ptr_next = r_rd_ptr + (PTR_WIDTH+1)'(w_rd_en);
  assign w_count_next  = w_wr_ptr_next - w_rd_ptr_next;
  assign w_wr_addr     = r_wr_ptr[PTR_WIDTH-1:0];
  assign w_rd_addr     = r_rd_ptr[PTR_WIDTH-1:0];

  generate
    if (RAM_TYPE == "distributed") begin : g_ram_dist
      (* ram_style = "distributed" *)
      logic [DATA_WIDTH:0] mem [c_DEPTH];
      always_ff @(posedge aclk) begin
        if (w_wr_en) mem[w_wr_addr] <= {s_axi4s.tlast, s_axi4s.tdata};
      end
      assign w_rd_data = mem[w_rd_addr];
    end else begin : g_ram_block
      (* ram_style = "block" *)
      logic [DATA_WIDTH:0] mem [c_DEPTH];
      always_ff @(posedge aclk) begin
        if (w_wr_en) mem[w_wr_addr] <= {s_axi4s.tlast, s_axi4s.tdata};
      end
      assign w_rd_data = mem[w_rd_addr];
    end
  endgenerate

  // Ready and the counters look ahead to the post-edge pointers so they stay registered
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_wr_ptr           <= '0;
      r_rd_ptr           <= '0;
      r_s_tready         <= 1'b0;
      acceptable_counter <= COUNTER_WIDTH'(c_DEPTH);
      data_count         <= '0;
    end else begin
      r_wr_ptr           <= w_wr_ptr_next;
      r_rd_ptr           <= w_rd_ptr_next;
      r_s_tready         <= (w_count_next != c_FULL);
      acceptable_counter <= COUNTER_WIDTH'(c_FULL - w_count_next);
      data_count         <= COUNTER_WIDTH'(w_count_next);
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_m_tvalid <= 1'b0;
      r_m_tdata  <= '0;
      r_m_tlast  <= 1'b0;
    end else if (w_rd_en) begin
      r_m_tvalid <= 1'b1;
      r_m_tlast  <= w_rd_data[DATA_WIDTH];
      r_m_tdata  <= w_rd_data[DATA_WIDTH-1:0];
    end else if (m_axi4s.tready) begin
      r_m_tvalid <= 1'b0;
    end
  end

  assign s_axi4s.tready = r_s_tready;
  assign m_axi4s.tvalid = r_m_tvalid;
  assign m_axi4s.tdata  = r_m_tdata;
  assign m_axi4s.tlast  = r_m_tlast;

endmodule
`default_nettype wire

// File: tb/tb_jelly_axi4s_fifo_acceptable.sv
`default_nettype none
// ============================================================================
// Module : tb_jelly_axi4s_fifo_acceptable
// Desc   : Self-checking bench: queue-based reference model plus directed scenarios
// Rev    : 1.0  initial release
// ============================================================================
module tb_jelly_axi4s_fifo_acceptable;

  localparam int c_DW    = 32;
  localparam int c_PW    = 4;
  localparam int c_CW    = 5;
  localparam int c_DEPTH = 16;

  logic            clk;
  logic            aresetn;
  logic [c_CW-1:0] acceptable_counter;
  logic [c_CW-1:0] data_count;

  jelly_axi4s_fifo_acceptable_if #(.DATA_WIDTH(c_DW)) s_axi4s ();
  jelly_axi4s_fifo_acceptable_if #(.DATA_WIDTH(c_DW)) m_axi4s ();

  jelly_axi4s_fifo_acceptable #(
    .DATA_WIDTH    (c_DW),
    .PTR_WIDTH     (c_PW),
    .COUNTER_WIDTH (c_CW),
    .RAM_TYPE      ("block")
  ) u_dut (
    .aresetn            (aresetn),
    .aclk               (clk),
    .s_axi4s            (s_axi4s),
    .m_axi4s            (m_axi4s),
    .acceptable_counter (acceptable_counter),
    .data_count         (data_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int n_in  = 0;
  int n_out = 0;

  function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endfunction

  function automatic logic last_of(input int k);
    return (k % 7) == 6;
  endfunction

  // Reference model: FIFO contents as a queue plus one output slot
  logic [c_DW:0] mq[$];
  logic [c_DW:0] sb_q[$];
  logic          model_ready = 1'b0;
  logic          exp_tready, exp_mvalid, exp_last;
  logic [c_DW-1:0] exp_data;
  int            exp_acc, exp_dc;

  initial begin
    logic [c_DW:0] beat;
    logic          acc_in, rd;
    forever begin
      @(negedge clk);
      if (model_ready) begin
        check("s_tready", s_axi4s.tready, exp_tready);
        check("m_tvalid", m_axi4s.tvalid, exp_mvalid);
        check("acceptable_counter", acceptable_counter, exp_acc);
        check("data_count", data_count, exp_dc);
        if (exp_mvalid) begin
          check("m_tdata", m_axi4s.tdata, exp_data);
          check("m_tlast", m_axi4s.tlast, exp_last);
        end
        if (m_axi4s.tvalid === 1'b1 && m_axi4s.tready) begin
          n_out++;
          check("sb_has_beat", sb_q.size() > 0, 1);
          if (sb_q.size() > 0) begin
            beat = sb_q.pop_front();
            check("sb_beat", {m_axi4s.tlast, m_axi4s.tdata}, beat);
          end
        end
      end
      if (s_axi4s.tvalid && s_axi4s.tready === 1'b1) begin
        n_in++;
        sb_q.push_back({s_axi4s.tlast, s_axi4s.tdata});
      end
      // Advance the model through the coming clock edge
      if (!aresetn) begin
        mq.delete();
        sb_q.delete();
        exp_tready  = 1'b0;
        exp_mvalid  = 1'b0;
        exp_data    = '0;
        exp_last    = 1'b0;
        exp_acc     = c_DEPTH;
        exp_dc      = 0;
        model_ready = 1'b1;
      end else if (model_ready) begin
        acc_in = s_axi4s.tvalid && exp_tready;
        rd     = (mq.size() > 0) && (!exp_mvalid || m_axi4s.tready);
        if (rd) begin
          beat       = mq.pop_front();
          exp_mvalid = 1'b1;
          exp_last   = beat[c_DW];
          exp_data   = beat[c_DW-1:0];
        end else if (m_axi4s.tready) begin
          exp_mvalid = 1'b0;
        end
        if (acc_in) mq.push_back({s_axi4s.tlast, s_axi4s.tdata});
        exp_tready = (mq.size() != c_DEPTH);
        exp_acc    = c_DEPTH - mq.size();
        exp_dc     = mq.size();
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer beats base.. back-to-back until n are taken or the budget runs out
  task automatic push_beats(input int n, input int base, input int budget, output int got);
    int start;
    start = n_in;
    for (int c = 0; c < budget; c++) begin
      got = n_in - start;
      if (got >= n) break;
      s_axi4s.tvalid = 1'b1;
      s_axi4s.tdata  = 32'(base + got);
      s_axi4s.tlast  = last_of(base + got);
      tick();
    end
    got = n_in - start;
    s_axi4s.tvalid = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int got, s_in, s_out, prev, cyc;
    aresetn        = 1'b0;
    s_axi4s.tvalid = 1'b0;
    s_axi4s.tdata  = '0;
    s_axi4s.tlast  = 1'b0;
    m_axi4s.tready = 1'b0;

    // Reset values and release
    repeat (3) tick();
    @(negedge clk);
    check("t1_rst_s_tready", s_axi4s.tready, 0);
    check("t1_rst_m_tvalid", m_axi4s.tvalid, 0);
    check("t1_rst_acceptable", acceptable_counter, 16);
    check("t1_rst_data_count", data_count, 0);
    tick();
    aresetn = 1'b1;
    @(negedge clk);
    check("t1_pre_release_s_tready", s_axi4s.tready, 0);
    tick();
    @(negedge clk);
    check("t1_release_s_tready", s_axi4s.tready, 1);

    // Single beat latency
    tick();
    s_axi4s.tvalid = 1'b1;
    s_axi4s.tdata  = 32'hA5A5_0001;
    s_axi4s.tlast  = 1'b1;
    m_axi4s.tready = 1'b1;
    @(negedge clk);
    check("t2_accept_ready", s_axi4s.tready, 1);
    tick();
    s_axi4s.tvalid = 1'b0;
    s_axi4s.tlast  = 1'b0;
    @(negedge clk);
    check("t2_n1_m_tvalid", m_axi4s.tvalid, 0);
    check("t2_n1_acceptable", acceptable_counter, 15);
    @(negedge clk);
    check("t2_n2_m_tvalid", m_axi4s.tvalid, 1);
    check("t2_n2_m_tdata", m_axi4s.tdata, 32'hA5A5_0001);
    check("t2_n2_m_tlast", m_axi4s.tlast, 1);
    check("t2_n2_acceptable", acceptable_counter, 16);
    @(negedge clk);
    check("t2_n3_m_tvalid", m_axi4s.tvalid, 0);

    // Fill with a stalled consumer
    tick();
    m_axi4s.tready = 1'b0;
    push_beats(20, 0, 40, got);
    check("t3_accepted", got, 17);
    @(negedge clk);
    check("t3_s_tready", s_axi4s.tready, 0);
    check("t3_acceptable", acceptable_counter, 0);
    check("t3_data_count", data_count, 16);
    check("t3_m_tvalid", m_axi4s.tvalid, 1);
    check("t3_m_tdata", m_axi4s.tdata, 0);

    // Drain after fill: no gaps
    tick();
    m_axi4s.tready = 1'b1;
    for (int k = 0; k < 17; k++) begin
      @(negedge clk);
      check("t4_m_tvalid", m_axi4s.tvalid, 1);
      check("t4_m_tdata", m_axi4s.tdata, k);
      if (k == 0) check("t4_d0_s_tready", s_axi4s.tready, 0);
      if (k == 1) check("t4_d1_s_tready", s_axi4s.tready, 1);
    end
    @(negedge clk);
    check("t4_end_m_tvalid", m_axi4s.tvalid, 0);

    // Random streaming with pointer wrap
    tick();
    s_in  = n_in;
    s_out = n_out;
    prev  = -1;
    cyc   = 0;
    while ((n_out - s_out) < 1000 && cyc < 20000) begin
      got = n_in - s_in;
      if (got >= 1000) begin
        s_axi4s.tvalid = 1'b0;
      end else begin
        if (!(s_axi4s.tvalid && got == prev)) s_axi4s.tvalid = ($urandom_range(0, 1) == 1);
        s_axi4s.tdata = 32'(100 + got);
        s_axi4s.tlast = last_of(100 + got);
      end
      prev = got;
      m_axi4s.tready = ($urandom_range(0, 1) == 1);
      tick();
      cyc++;
    end
    s_axi4s.tvalid = 1'b0;
    m_axi4s.tready = 1'b1;
    check("t5_beats_in", n_in - s_in, 1000);
    check("t5_beats_out", n_out - s_out, 1000);
    repeat (4) tick();
    check("t5_sb_empty", sb_q.size(), 0);

    // Reset with beats buffered and the output stalled
    m_axi4s.tready = 1'b0;
    push_beats(10, 2000, 30, got);
    check("t6_accepted", got, 10);
    repeat (2) tick();
    @(negedge clk);
    check("t6_pre_data_count", data_count, 9);
    check("t6_pre_m_tvalid", m_axi4s.tvalid, 1);
    s_out = n_out;
    tick();
    aresetn = 1'b0;
    tick();
    aresetn = 1'b1;
    @(negedge clk);
    check("t6_rst_m_tvalid", m_axi4s.tvalid, 0);
    check("t6_rst_acceptable", acceptable_counter, 16);
    check("t6_rst_data_count", data_count, 0);
    tick();
    m_axi4s.tready = 1'b1;
    repeat (20) tick();
    check("t6_no_stale_beats", n_out - s_out, 0);
    push_beats(3, 3000, 10, got);
    check("t6_new_accepted", got, 3);
    repeat (6) tick();
    check("t6_new_out", n_out - s_out, 3);
    check("t6_sb_empty", sb_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
